frame_write_sched: RTL and testbench
====================================

# frame_write_sched

Sequencer and write-port arbiter for the frame memory. On `start` it validates and latches the bounding box, runs the header generator, then the pixel body writer, and multiplexes their write ports onto the single memory write port. Body addresses are relocated past the header words. A per-phase watchdog ensures the controller always terminates with `done`.

## Interface
- `ADDR_W`, 24: memory address width.
- `DATA_W`, 16: memory data width.
- `BODY_BASE`, 4: offset added to every body-writer address.
- `TIMEOUT`, 1024: maximum cycles per run phase before the controller aborts.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE, DONE and ERR.
- `xMin`, `xMax`, `yMin`, `yMax`  in  11 each  bounding box.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  level; high in DONE and ERR.
- `err_code`  out  2  00 ok, 01 bad box, 10 timeout, 11 stray write.
- `wr_count`  out  16  number of memory writes issued this frame; saturates at 0xFFFF.
- `box_xMin`, `box_xMax`, `box_yMin`, `box_yMax`  out  11 each  latched box, held stable for the clients.
- `hdr_start`  out  1  one-cycle pulse to the header generator.
- `hdr_done`  in  1  header generator done.
- `hdr_addr`, `hdr_wren`, `hdr_wrdata`  in  ADDR_W / 1 / DATA_W  header generator write port.
- `body_start`  out  1  one-cycle pulse to the body writer.
- `body_done`  in  1  body writer done.
- `body_addr`, `body_wren`, `body_wrdata`  in  ADDR_W / 1 / DATA_W  body writer write port.
- `mem_addr`, `mem_wren`, `mem_wrdata`  out  ADDR_W / 1 / DATA_W  registered memory write port.

## Operation
- States: IDLE, CHECK, HDR_START, HDR_RUN, BODY_START, BODY_RUN, DONE, ERR.
- IDLE/DONE/ERR with `start`=1:
  - latch the four bounds into `box_*`;
  - clear `err_code` and `wr_count`;
  - go to CHECK.
- CHECK:
  - if `box_xMax <= box_xMin` or `box_yMax <= box_yMin` (unsigned compare): `err_code`=01, go to ERR;
  - otherwise go to HDR_START.
- HDR_START:
  - `hdr_start`=1 for this cycle only;
  - clear the watchdog;
  - go to HDR_RUN.
- HDR_RUN:
  - header port is granted;
  - when `hdr_done`=1, go to BODY_START;
  - `hdr_done` is ignored in every other state.
- BODY_START / BODY_RUN: same as the header phase, using the body signals.
  - `body_done`=1 in BODY_RUN goes to DONE.
- Watchdog:
  - counts cycles in each RUN state;
  - if it reaches `TIMEOUT-1` without the phase's done, set `err_code`=10 and go to ERR.
- Grant mux:
  - HDR_RUN: `mem_addr`=`hdr_addr`.
  - BODY_RUN: `mem_addr`=(`body_addr`+`BODY_BASE`) mod 2^ADDR_W.
  - `mem_wren` and `mem_wrdata` follow the granted client.
  - In every other state `mem_wren`=0, and `mem_addr`/`mem_wrdata` are 0.
- Stray write:
  - any non-granted client asserting `wren` while `busy` sets `err_code`=11 and goes to ERR;
  - the stray write is never forwarded;
  - header stray writes are checked from BODY_START onward; body stray writes are checked from CHECK through HDR_RUN.
- Error precedence:
  - if timeout and stray write occur in the same cycle, 11 wins;
  - if the phase's done and a timeout occur in the same cycle, done wins.
- `wr_count` increments on each cycle in which `mem_wren` is registered as 1.
- `busy`=1 in CHECK through BODY_RUN.
- `start` while busy is ignored.

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0, including `box_*`, `wr_count`, `err_code`, both start pulses and `mem_*`.
- Reset mid-frame:
  - takes effect at the next edge, regardless of client state;
  - client start pulses are never issued on reset exit.
- `start` sampled in cycle N:
  - CHECK in N+1;
  - `hdr_start` high in N+2;
  - HDR_RUN from N+3.
- Client write presented in cycle M while granted: appears on `mem_*` in M+1 (one register stage).
  - A write in the last granted cycle (the one where done is seen) is still forwarded.
- `hdr_done` seen in cycle K:
  - `body_start` high in K+1;
  - BODY_RUN from K+2.
- `body_done` seen in cycle K: `done`=1 from K+1, held until the next accepted `start`.
- `done` falls in the cycle after `start` is accepted.
- Minimum frame (done asserted on each client's first RUN cycle): `done` 6 cycles after `start`.

## Test plan
- Box (10,20,5,9); header writes 4 words in its first 4 HDR_RUN cycles, then done; body writes addr 0..39; done.
  - Expect `mem_addr` 0..3, then 4..43.
  - `wr_count`=44, `err_code`=00, `done`=1.
- Box `xMax`=`xMin`=7 -> ERR 2 cycles after `start`.
  - `err_code`=01, no start pulses, `mem_wren` never 1.
- `TIMEOUT`=16 and `hdr_done` held 0 -> ERR after 16 HDR_RUN cycles.
  - `err_code`=10, `body_start` never pulses.
- `body_wren`=1 during HDR_RUN -> next cycle ERR.
  - `err_code`=11, the body write is absent from `mem_*`.
- `rst` asserted during BODY_RUN with `body_wren`=1 -> next cycle all outputs 0, state IDLE.
  - A later `start` runs a clean frame with `wr_count` restarting from 0.
- `start` re-asserted while busy -> ignored.
  - `start` in DONE -> `done` drops next cycle and a new `box_*` is latched.

Source files
------------

// File: rtl/frame_write_sched.sv
// Frame memory write sequencer: validates the box, runs the header then body
// clients, and arbitrates their write ports onto one registered memory port.
module frame_write_sched #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BODY_BASE = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       xMin,
  input  logic [10:0]       xMax,
  input  logic [10:0]       yMin,
  input  logic [10:0]       yMax,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [15:0]       wr_count,
  output logic [10:0]       box_xMin,
  output logic [10:0]       box_xMax,
  output logic [10:0]       box_yMin,
  output logic [10:0]       box_yMax,
  output logic              hdr_start,
  input  logic              hdr_done,
  input  logic [ADDR_W-1:0] hdr_addr,
  input  logic              hdr_wren,
  input  logic [DATA_W-1:0] hdr_wrdata,
  output logic              body_start,
  input  logic              body_done,
  input  logic [ADDR_W-1:0] body_addr,
  input  logic              body_wren,
  input  logic [DATA_W-1:0] body_wrdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wrdata
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BODY_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_HDR_START, S_HDR_RUN,
    S_BODY_START, S_BODY_RUN, S_DONE, S_ERR
  } state_t;

  state_t            state, next_state;
  logic [WD_W-1:0]   wd;
  logic              accept, hdr_stray, body_stray, wd_expired;
  logic              err_load;
  logic [1:0]        err_next;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_wren;
  logic [DATA_W-1:0] grant_data;

  assign accept     = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign hdr_stray  = hdr_wren && (state == S_BODY_START || state == S_BODY_RUN);
  assign body_stray = body_wren && (state == S_CHECK || state == S_HDR_START || state == S_HDR_RUN);
  assign wd_expired = (wd == WD_LAST);

  assign busy       = (state == S_CHECK) || (state == S_HDR_START) || (state == S_HDR_RUN) ||
                      (state == S_BODY_START) || (state == S_BODY_RUN);
  assign done       = (state == S_DONE) || (state == S_ERR);
  assign hdr_start  = (state == S_HDR_START);
  assign body_start = (state == S_BODY_START);

  // A stray write outranks every other event; a phase's done outranks its timeout.
  always_comb begin
    next_state = state;
    err_load   = 1'b0;
    err_next   = 2'b00;
    if (hdr_stray || body_stray) begin
      next_state = S_ERR;
      err_load   = 1'b1;
      err_next   = 2'b11;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) next_state = S_CHECK;
        S_CHECK: begin
          if (box_xMax <= box_xMin || box_yMax <= box_yMin) begin
            next_state = S_ERR;
            err_load   = 1'b1;
            err_next   = 2'b01;
          end else begin
            next_state = S_HDR_START;
          end
        end
        S_HDR_START: next_state = S_HDR_RUN;
        S_HDR_RUN: begin
          if (hdr_done) begin
            next_state = S_BODY_START;
          end else if (wd_expired) begin
            next_state = S_ERR;
            err_load   = 1'b1;
            err_next   = 2'b10;
          end
        end
        S_BODY_START: next_state = S_BODY_RUN;
        S_BODY_RUN: begin
          if (body_done) begin
            next_state = S_DONE;
          end else if (wd_expired) begin
            next_state = S_ERR;
            err_load   = 1'b1;
            err_next   = 2'b10;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_addr = '0;
    grant_wren = 1'b0;
    grant_data = '0;
    if (state == S_HDR_RUN) begin
      grant_addr = hdr_addr;
      grant_wren = hdr_wren;
      grant_data = hdr_wrdata;
    end else if (state == S_BODY_RUN) begin
      grant_addr = body_addr + BASE;
      grant_wren = body_wren;
      grant_data = body_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wd         <= '0;
      err_code   <= 2'b00;
      wr_count   <= 16'd0;
      box_xMin   <= '0;
      box_xMax   <= '0;
      box_yMin   <= '0;
      box_yMax   <= '0;
      mem_addr   <= '0;
      mem_wren   <= 1'b0;
      mem_wrdata <= '0;
    end else begin
      state      <= next_state;
      mem_addr   <= grant_addr;
      mem_wren   <= grant_wren;
      mem_wrdata <= grant_data;
      if (state == S_HDR_START || state == S_BODY_START)
        wd <= '0;
      else if (state == S_HDR_RUN || state == S_BODY_RUN)
        wd <= wd + 1'b1;
      if (accept) begin
        box_xMin <= xMin;
        box_xMax <= xMax;
        box_yMin <= yMin;
        box_yMax <= yMax;
        err_code <= 2'b00;
        wr_count <= 16'd0;
      end else begin
        if (err_load) err_code <= err_next;
        // Counts alongside the registered write so it matches mem_wren.
        if (grant_wren && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_write_sched.sv
// Randomized frame-level bench: each frame's timeline and write stream are
// derived from the sequencing rules and compared cycle by cycle.
module tb_frame_write_sched;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BB = 4;
  localparam int TO = 48;
  localparam int MAXC = 160;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [10:0]   xMin, xMax, yMin, yMax;
  logic          busy, done;
  logic [1:0]    err_code;
  logic [15:0]   wr_count;
  logic [10:0]   box_xMin, box_xMax, box_yMin, box_yMax;
  logic          hdr_start, hdr_done, hdr_wren;
  logic [AW-1:0] hdr_addr;
  logic [DW-1:0] hdr_wrdata;
  logic          body_start, body_done, body_wren;
  logic [AW-1:0] body_addr;
  logic [DW-1:0] body_wrdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wrdata;

  frame_write_sched #(.ADDR_W(AW), .DATA_W(DW), .BODY_BASE(BB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .busy(busy), .done(done), .err_code(err_code), .wr_count(wr_count),
    .box_xMin(box_xMin), .box_xMax(box_xMax), .box_yMin(box_yMin), .box_yMax(box_yMax),
    .hdr_start(hdr_start), .hdr_done(hdr_done), .hdr_addr(hdr_addr),
    .hdr_wren(hdr_wren), .hdr_wrdata(hdr_wrdata),
    .body_start(body_start), .body_done(body_done), .body_addr(body_addr),
    .body_wren(body_wren), .body_wrdata(body_wrdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wrdata(mem_wrdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Per-frame stimulus tables, indexed by cycle relative to the start cycle.
  logic          hW [MAXC], hD [MAXC], bW [MAXC], bD [MAXC], stN [MAXC];
  logic [AW-1:0] hA [MAXC], bA [MAXC];
  logic [DW-1:0] hDat [MAXC], bDat [MAXC];

  int   H, B, sc, scFix, rc, endC, errExp, hLo, hHi, bLo, bHi, bsCyc, hEnd, bEnd, frameNo;
  int   strayKind;
  bit   hdrTo, bodyTo, badBox;
  logic [10:0] nx0, nx1, ny0, ny1;
  bit   prevDone;
  logic [1:0] prevErr;
  int   prevCnt;
  logic [10:0] px0, px1, py0, py1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".err"}, 32'(err_code), 0);
    checkOutput({tag, ".cnt"}, 32'(wr_count), 0);
    checkOutput({tag, ".hs"}, 32'(hdr_start), 0);
    checkOutput({tag, ".bs"}, 32'(body_start), 0);
    checkOutput({tag, ".mwren"}, 32'(mem_wren), 0);
    checkOutput({tag, ".maddr"}, 32'(mem_addr), 0);
    checkOutput({tag, ".mdata"}, 32'(mem_wrdata), 0);
    checkOutput({tag, ".box"}, {box_xMin, box_xMax, box_yMin[9:0]}, 0);
    checkOutput({tag, ".boxy"}, 32'({box_yMin, box_yMax}), 0);
  endtask

  task automatic newBox(input bit isBad);
    nx0 = 11'($urandom_range(2000, 0));
    nx1 = nx0 + 11'($urandom_range(40, 1));
    ny0 = 11'($urandom_range(2000, 0));
    ny1 = ny0 + 11'($urandom_range(40, 1));
    if (isBad) begin
      if ($urandom_range(1, 0) == 0) begin
        nx0 = 11'($urandom_range(2047, 10));
        nx1 = nx0 - 11'($urandom_range(10, 0));
      end else begin
        ny0 = 11'($urandom_range(2047, 10));
        ny1 = ny0 - 11'($urandom_range(10, 0));
      end
    end
  endtask

  // Derive the expected frame timeline and fill the client stimulus tables.
  task automatic buildFrame();
    hEnd = hdrTo ? 2 + TO : 2 + H;
    bEnd = bodyTo ? hEnd + 1 + TO : hEnd + 1 + B;
    sc = -1;
    if (scFix > 0) sc = scFix;
    else if (strayKind == 1 && !badBox) sc = $urandom_range(hEnd, 1);
    else if (strayKind == 2 && !badBox && !hdrTo) sc = $urandom_range(bEnd, hEnd + 1);
    hLo = 3; hHi = 2; bLo = 1; bHi = 0; bsCyc = -1;
    if (badBox) begin
      endC = 2; errExp = 1;
    end else if (sc >= 1 && sc <= hEnd) begin
      endC = sc + 1; errExp = 3; hHi = (sc < hEnd) ? sc : hEnd;
    end else if (hdrTo) begin
      endC = hEnd + 1; errExp = 2; hHi = hEnd;
    end else begin
      hHi = hEnd; bsCyc = hEnd + 1; bLo = hEnd + 2;
      if (sc > hEnd && sc <= bEnd) begin
        endC = sc + 1; errExp = 3; bHi = (sc < bEnd) ? sc : bEnd;
      end else begin
        endC = bEnd + 1; errExp = bodyTo ? 2 : 0; bHi = bEnd;
      end
    end
    if (rc == -2) rc = $urandom_range(endC - 1, 1);
    for (int c = 0; c < MAXC; c++) begin
      hW[c] = 0; hD[c] = 0; bW[c] = 0; bD[c] = 0; stN[c] = 0;
      hA[c] = AW'($urandom); bA[c] = AW'($urandom);
      hDat[c] = DW'($urandom); bDat[c] = DW'($urandom);
      if (c <= 2) hD[c] = 1'($urandom);
      if (c >= 1 && c <= 2) hW[c] = 1'($urandom);
      if (c >= 3 && c <= hEnd) begin
        hW[c] = 1'($urandom);
        hD[c] = (!hdrTo && c == hEnd);
      end
      if (c > hEnd) hD[c] = 1'($urandom);
      if (c <= hEnd + 1) bD[c] = 1'($urandom);
      if (c == hEnd + 1) bW[c] = 1'($urandom);
      if (c >= hEnd + 2 && c <= bEnd) begin
        bW[c] = 1'($urandom);
        bD[c] = (!bodyTo && c == bEnd);
      end
      if (c >= 1 && c < endC) stN[c] = ($urandom_range(7, 0) == 0);
    end
    if (sc >= 1 && sc <= hEnd) bW[sc] = 1;
    if (sc > hEnd) hW[sc] = 1;
    for (int c = endC; c < MAXC; c++) begin
      hW[c] = 0; hD[c] = 0; bW[c] = 0; bD[c] = 0; stN[c] = 0;
    end
  endtask

  task automatic applyStimulus();
    int cnt, lastC, g;
    logic eW;
    logic [AW-1:0] eA;
    logic [DW-1:0] eD;
    string t;
    cnt = prevCnt;
    lastC = (rc >= 0) ? rc + 1 : endC + 1;
    for (int c = 0; c <= lastC; c++) begin
      rst   = (c == rc);
      start = (c == 0) || (stN[c] && c != rc + 1);
      xMin  = (c == 0) ? nx0 : 11'($urandom);
      xMax  = (c == 0) ? nx1 : 11'($urandom);
      yMin  = (c == 0) ? ny0 : 11'($urandom);
      yMax  = (c == 0) ? ny1 : 11'($urandom);
      hdr_wren = hW[c]; hdr_done = hD[c]; hdr_addr = hA[c]; hdr_wrdata = hDat[c];
      body_wren = bW[c]; body_done = bD[c]; body_addr = bA[c]; body_wrdata = bDat[c];
      @(negedge clk);
      t = $sformatf("f%0d.c%0d", frameNo, c);
      if (rc >= 0 && c == rc + 1) begin
        checkAllZero(t);
      end else begin
        eW = 0; eA = '0; eD = '0;
        if (c >= 1) begin
          g = c - 1;
          if (g >= hLo && g <= hHi) begin
            eW = hW[g]; eA = hA[g]; eD = hDat[g];
          end else if (g >= bLo && g <= bHi) begin
            eW = bW[g]; eA = bA[g] + AW'(BB); eD = bDat[g];
          end
        end
        if (c == 1) cnt = 0;
        if (eW && cnt < 16'hFFFF) cnt++;
        checkOutput({t, ".busy"}, 32'(busy), (c >= 1 && c < endC));
        checkOutput({t, ".done"}, 32'(done), (c == 0) ? 32'(prevDone) : 32'(c >= endC));
        checkOutput({t, ".err"}, 32'(err_code),
                    (c == 0) ? 32'(prevErr) : ((c >= endC) ? errExp : 0));
        checkOutput({t, ".hs"}, 32'(hdr_start), (c == 2 && endC > 2));
        checkOutput({t, ".bs"}, 32'(body_start), (c == bsCyc));
        checkOutput({t, ".mwren"}, 32'(mem_wren), 32'(eW));
        checkOutput({t, ".maddr"}, 32'(mem_addr), 32'(eA));
        checkOutput({t, ".mdata"}, 32'(mem_wrdata), 32'(eD));
        checkOutput({t, ".cnt"}, 32'(wr_count), cnt);
        checkOutput({t, ".bx"}, 32'({box_xMin, box_xMax}),
                    (c == 0) ? 32'({px0, px1}) : 32'({nx0, nx1}));
        checkOutput({t, ".by"}, 32'({box_yMin, box_yMax}),
                    (c == 0) ? 32'({py0, py1}) : 32'({ny0, ny1}));
      end
      @(posedge clk);
      #1;
    end
    if (rc >= 0) begin
      prevDone = 0; prevErr = 0; prevCnt = 0;
      px0 = 0; px1 = 0; py0 = 0; py1 = 0;
    end else begin
      prevDone = 1; prevErr = 2'(errExp); prevCnt = cnt;
      px0 = nx0; px1 = nx1; py0 = ny0; py1 = ny1;
    end
    frameNo++;
  endtask

  task automatic setKnobs(input int h, input int b, input bit hto, input bit bto,
                          input bit bb, input int sk);
    H = h; B = b; hdrTo = hto; bodyTo = bto; badBox = bb; strayKind = sk;
    scFix = 0; rc = -1;
    newBox(bb);
  endtask

  initial begin
    frameNo = 0;
    prevDone = 0; prevErr = 0; prevCnt = 0;
    px0 = 0; px1 = 0; py0 = 0; py1 = 0;
    rst = 1; start = 0;
    xMin = 0; xMax = 0; yMin = 0; yMax = 0;
    hdr_done = 0; hdr_wren = 0; hdr_addr = '0; hdr_wrdata = '0;
    body_done = 0; body_wren = 0; body_addr = '0; body_wrdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;

    // Header writes 4 words, body writes addresses 0..39.
    setKnobs(4, 40, 0, 0, 0, 0);
    nx0 = 10; nx1 = 20; ny0 = 5; ny1 = 9;
    buildFrame();
    for (int g = hLo; g <= hHi; g++) begin hW[g] = 1; hA[g] = AW'(g - hLo); end
    for (int g = bLo; g <= bHi; g++) begin bW[g] = 1; bA[g] = AW'(g - bLo); end
    applyStimulus();

    // Degenerate box xMax == xMin.
    setKnobs(3, 3, 0, 0, 1, 0);
    nx0 = 7; nx1 = 7;
    buildFrame();
    applyStimulus();

    // Header never finishes.
    setKnobs(3, 3, 1, 0, 0, 0);
    buildFrame();
    applyStimulus();

    // Body stray during the header phase.
    setKnobs(5, 3, 0, 0, 0, 0);
    scFix = 5;
    buildFrame();
    applyStimulus();

    // Reset during BODY_RUN with a body write pending, then a clean frame.
    setKnobs(2, 6, 0, 0, 0, 0);
    buildFrame();
    rc = bLo + 1;
    bW[rc] = 1;
    applyStimulus();
    setKnobs(2, 3, 0, 0, 0, 0);
    buildFrame();
    applyStimulus();

    // start held high all through a busy frame.
    setKnobs(3, 4, 0, 0, 0, 0);
    buildFrame();
    for (int c = 1; c < endC; c++) stN[c] = 1;
    applyStimulus();

    // Stray write on the same cycle the header watchdog expires.
    setKnobs(3, 3, 1, 0, 0, 0);
    scFix = 2 + TO;
    buildFrame();
    applyStimulus();

    // Done on the same cycle the watchdog would expire, in both phases.
    setKnobs(TO, TO, 0, 0, 0, 0);
    buildFrame();
    applyStimulus();

    for (int f = 0; f < 40; f++) begin
      setKnobs(($urandom_range(7, 0) == 0) ? TO : $urandom_range(6, 1),
               ($urandom_range(7, 0) == 0) ? TO : $urandom_range(6, 1),
               $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0,
               $urandom_range(9, 0) == 0,
               ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(2, 1));
      if ($urandom_range(7, 0) == 0) rc = -2;
      buildFrame();
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
